// File: rtl/mux_rr_arbiter_if.sv
// Channel bundle between the four upstream sources, the round-robin merge and
// the downstream consumer of the merged word.
// Ports: in_valid/in_data/in_ready (four source channels), out_valid/out_data/
//        out_sel/out_ready (merged channel; out_sel names the source channel).
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  // master: the environment (sources + downstream sink)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // slave: the merge block itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// 4-to-1 round-robin merge of valid/ready channels into one registered word.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle with out_ready high.
// Backpressure: while out_valid && !out_ready all state is frozen and in_ready is 0.
// Ports: clk, reset (async active-high), bus (slave side of mux_rr_arbiter_if):
//   in_valid[3:0], in_data[4*WIDTH-1:0], in_ready[3:0] (one-hot or zero, combinational),
//   out_valid, out_data[WIDTH-1:0], out_sel[1:0] (all registered), out_ready.
module mux_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  mux_rr_arbiter_if.slave  bus
);

  logic [1:0]       last_grant;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             load;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_sel_q;

  // Round-robin search starting just after last_grant. Walking the offsets
  // from farthest (4 == last_grant itself) to nearest (1) lets the nearest
  // requesting channel overwrite the others, so no "found" flag is needed.
  always_comb begin
    grant = last_grant + 2'd1;
    idx   = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (bus.in_valid[idx]) grant = idx;
    end
  end

  // The output register can take a word when empty or draining this edge.
  assign load = (!out_valid_q || bus.out_ready) && (|bus.in_valid);

  assign bus.in_ready = load ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
      last_grant  <= 2'b11;  // channel 0 wins first after reset
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[grant*WIDTH +: WIDTH];
      out_sel_q   <= grant;
      last_grant  <= grant;
    end else if (bus.out_ready) begin
      // Drain without refill: data and select keep their last values.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
